// File: rtl/mbs_bus_arbiter.sv
// Round-robin shared-bus arbiter for N_CPU masters with atomic lock support.
// The owner may lock the bus; an optional timeout forces release and blocks
// the owner from re-locking until it drops lock_req.
module mbs_bus_arbiter #(
  parameter  int N_CPU    = 2,
  parameter  int ADDR_W   = 32,
  parameter  int LOCK_MAX = 255,
  localparam int SEL_W    = (N_CPU > 2) ? $clog2(N_CPU) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CPU-1:0]        req,
  input  logic [N_CPU-1:0]        lock_req,
  input  logic [N_CPU*ADDR_W-1:0] lock_addr_in,
  output logic [N_CPU-1:0]        grant,
  output logic [SEL_W-1:0]        cpu_sel,
  output logic [N_CPU-1:0]        cpu_pause,
  output logic                    lock_flag,
  output logic [ADDR_W-1:0]       lock_addr,
  output logic                    lock_timeout
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
  localparam int LIM   = (LOCK_MAX > 0) ? LOCK_MAX - 1 : 0;

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t             state, state_n;
  logic [N_CPU-1:0]   grant_q, grant_n;
  logic [SEL_W-1:0]   owner, owner_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0]  laddr, laddr_n;
  logic               tmo_q, tmo_n;
  logic [N_CPU-1:0]   blocked;

  logic [N_CPU-1:0]   owner_oh;
  logic               owner_req;
  logic               owner_lock;
  logic [ADDR_W-1:0]  owner_addr;
  logic               forced;
  logic [N_CPU-1:0]   arb_req;
  logic               arb_valid;
  logic [SEL_W-1:0]   arb_idx;
  logic [N_CPU-1:0]   arb_oh;
  logic [SEL_W-1:0]   arb_ptr;
  int unsigned        idx;
  logic               do_arb;

  assign owner_oh   = N_CPU'(1) << owner;
  assign owner_req  = req[owner];
  assign owner_lock = lock_req[owner];
  assign owner_addr = lock_addr_in[int'(owner)*ADDR_W +: ADDR_W];

  // Forced release fires on the cycle the counter sits at LOCK_MAX-1,
  // so the exit lands exactly LOCK_MAX cycles after lock entry.
  assign forced  = (state == LOCKED) && owner_lock && (LOCK_MAX != 0) &&
                   (cnt == CNT_W'(LIM));
  assign arb_req = forced ? (req & ~owner_oh) : req;

  // Round-robin search starting at the pointer, wrapping modulo N_CPU.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N_CPU; i++) begin
      idx = (int'(ptr) + i) % N_CPU;
      if (!arb_valid && arb_req[idx]) begin
        arb_valid = 1'b1;
        arb_idx   = SEL_W'(idx);
      end
    end
  end

  assign arb_oh  = N_CPU'(1) << arb_idx;
  assign arb_ptr = SEL_W'((int'(arb_idx) + 1) % N_CPU);

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    laddr_n = laddr;
    tmo_n   = 1'b0;
    do_arb  = 1'b0;
    unique case (state)
      IDLE: do_arb = 1'b1;
      GRANT: begin
        if (owner_lock && !blocked[owner]) begin
          state_n = LOCKED;
          laddr_n = owner_addr;
          cnt_n   = '0;
        end else if (!owner_req) begin
          do_arb = 1'b1;
        end
      end
      LOCKED: begin
        cnt_n = cnt + 1'b1;
        if (!owner_lock) begin
          laddr_n = '0;
          if (owner_req) state_n = GRANT;
          else           do_arb  = 1'b1;
        end else if (forced) begin
          tmo_n   = 1'b1;
          laddr_n = '0;
          do_arb  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    // Shared tail: new grant (pointer advances) or fall back to idle.
    if (do_arb) begin
      if (arb_valid) begin
        state_n = GRANT;
        owner_n = arb_idx;
        grant_n = arb_oh;
        ptr_n   = arb_ptr;
      end else begin
        state_n = IDLE;
        grant_n = '0;
      end
    end
  end

  // State and output registers; blocked[i] clears once lock_req[i] drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      laddr   <= '0;
      tmo_q   <= 1'b0;
      blocked <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      laddr   <= laddr_n;
      tmo_q   <= tmo_n;
      blocked <= (blocked & lock_req) | (forced ? owner_oh : '0);
    end
  end

  assign grant        = grant_q;
  assign cpu_sel      = owner;
  assign cpu_pause    = req & ~grant_q;
  assign lock_flag    = (state == LOCKED);
  assign lock_addr    = laddr;
  assign lock_timeout = tmo_q;

endmodule

// File: doc/mbs_bus_arbiter.md
# mbs_bus_arbiter

Parametrised shared-bus arbiter for the MBSsoc multi-core top, generalising the fixed two-CPU select/pause/lock scheme to N_CPU masters. It grants a single shared data/address/control bus to one CPU at a time using round-robin priority. It pauses every requester that is not granted. It supports an atomic lock: the bus owner holds the bus across several transactions, with the locked address recorded and an optional timeout that forces release.

## Interface
- N_CPU, 2, number of bus masters (2..16)
- ADDR_W, 32, width of lock address
- LOCK_MAX, 255, max consecutive cycles in LOCKED before forced release; 0 disables the timeout
- SEL_W, $clog2(N_CPU) (min 1), width of cpu_sel (derived localparam)

- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_CPU  per-CPU bus request, level
- lock_req  in  N_CPU  per-CPU lock request, level; honoured only from the current owner
- lock_addr_in  in  N_CPU*ADDR_W  per-CPU lock address; CPU i occupies bits [i*ADDR_W +: ADDR_W]
- grant  out  N_CPU  one-hot bus grant, or all zero when idle; registered
- cpu_sel  out  SEL_W  index of the current owner; holds its last value when idle
- cpu_pause  out  N_CPU  req & ~grant; combinational from req and registered grant
- lock_flag  out  1  high while in the LOCKED state
- lock_addr  out  ADDR_W  owner's lock address, captured on lock entry; 0 when not locked
- lock_timeout  out  1  one-cycle pulse on a forced release

## Operation
- States: IDLE, GRANT, LOCKED.
- Reset:
  - state=IDLE, grant=0, cpu_sel=0, lock_flag=0, lock_addr=0, lock_timeout=0, lock counter=0.
  - RR pointer=0, so CPU0 has highest priority first.
- Arbitration function: pick the first asserted req starting at the RR pointer and wrapping modulo N_CPU.
  - On any new grant to CPU k, the pointer becomes (k+1) mod N_CPU.
- IDLE:
  - If any req is high → GRANT to the arbitrated CPU.
  - Otherwise stay in IDLE.
- GRANT (owner o):
  - lock_req[o]=1 → LOCKED. Capture lock_addr_in[o] and clear the counter. This takes precedence over req[o] dropping in the same cycle.
  - Else req[o]=1 → hold the grant. There is no preemption.
  - Else, with other requests pending → grant moves directly to the next arbitrated CPU, with no idle bubble.
  - Else → IDLE, grant=0.
- LOCKED (owner o):
  - Grant is held regardless of req[o]. All other requesters are paused.
  - lock_req from non-owners is ignored.
  - The counter increments each cycle.
  - lock_req[o]=0 → exit the lock: lock_flag=0, lock_addr=0. Then:
    - req[o]=1 → GRANT, same owner.
    - else → arbitrate as in GRANT.
  - LOCK_MAX≠0 and counter reaches LOCK_MAX-1 while lock_req[o] is still high → forced exit:
    - lock_timeout pulses.
    - Ownership passes to the next requester excluding o, or goes to IDLE if there is none.
    - o must deassert lock_req and re-request before it can lock again.
  - While lock_req[o] stays high after a forced release, o may not re-lock.
- Reset mid-operation, in any state: all outputs return to their reset values on the next edge. An outstanding lock is dropped without a lock_timeout pulse.

## Timing
- All decisions use inputs sampled at edge n and take effect at edge n+1.
- Request latency: req rising before edge n with the bus idle → grant at n+1.
- Handover: owner drops req before edge n → new owner's grant at n+1, old grant low at n+1.
- Lock: lock_req[o] sampled at edge n → lock_flag and lock_addr valid at n+1.
- Unlock: lock_req[o] low at edge n → lock_flag=0 at n+1.
- Timeout: the forced exit occurs LOCK_MAX cycles after lock_flag rose. lock_timeout is high for exactly that one cycle.
- cpu_pause follows req in the same cycle, with no register.
- grant is never multi-hot. The grant-to-grant gap is 0 cycles when a handover is pending.

## Test plan
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles, req=0.
  - Required: all outputs 0, state IDLE. req=2'b01 → grant=01 one cycle later, cpu_sel=0.
- Round-robin, N_CPU=4:
  - Stimulus: req=4'b1111 held; each owner drops req for one cycle after 3 cycles of tenure.
  - Required: grant sequence 0001→0010→0100→1000→0001. cpu_pause = req & ~grant every cycle.
- Zero-bubble handover:
  - Stimulus: owner CPU0 drops req at the same edge CPU1 is requesting.
  - Required: grant=10 on the next cycle with no all-zero cycle.
- Lock hold:
  - Stimulus: CPU1 owns the bus; lock_req[1]=1, lock_addr_in[1]=32'h0000_1F00; req[1] dropped while req[0]=1.
  - Required: lock_flag=1 and lock_addr=0x1F00 next cycle; grant stays 10 and cpu_pause[0]=1.
  - Then lock_req[1]=0 → lock_flag=0, lock_addr=0, grant=01 next cycle.
- Timeout, LOCK_MAX=8:
  - Stimulus: CPU0 holds lock_req high indefinitely while CPU1 requests.
  - Required: lock_timeout pulses exactly once, 8 cycles after lock_flag rose. Grant moves to CPU1 and CPU0 cannot re-lock until lock_req[0] toggles.
- Reset mid-lock:
  - Stimulus: rst asserted while LOCKED.
  - Required: grant=0, lock_flag=0, lock_addr=0, lock_timeout stays 0, RR pointer back to CPU0.
